// File: rtl/alu.sv
// Two-operand ALU (ADD/SUB/OR/AND) with a combinational result.
// Zero/negative/carry/overflow flags are captured into registers on every clock edge.
module alu #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [1:0]       func,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             flag_v
);

    typedef enum logic [1:0] {
        FUNC_ADD = 2'd0,
        FUNC_SUB = 2'd1,
        FUNC_OR  = 2'd2,
        FUNC_AND = 2'd3
    } func_e;

    logic             is_sub;
    logic [WIDTH-1:0] b_op;
    logic [WIDTH:0]   sum_ext;
    logic             arith_v;

    logic             z_d, n_d, c_d, v_d;
    logic             z_q, n_q, c_q, v_q;

    // SUB is done as a + ~b + 1, so one adder serves both arithmetic codes.
    // Its carry-out is then the "no borrow" indication.
    assign is_sub  = (func == FUNC_SUB);
    assign b_op    = is_sub ? ~b : b;
    assign sum_ext = {1'b0, a} + {1'b0, b_op} + {{WIDTH{1'b0}}, is_sub};

    // Overflow: the two adder inputs have the same sign, but the sum's sign differs.
    // With b inverted for SUB, this also covers the subtract case.
    assign arith_v = (a[WIDTH-1] == b_op[WIDTH-1]) &&
                     (sum_ext[WIDTH-1] != a[WIDTH-1]);

    always_comb begin
        result = '0;
        c_d    = 1'b0;
        v_d    = 1'b0;
        case (func_e'(func))
            FUNC_ADD, FUNC_SUB: begin
                result = sum_ext[WIDTH-1:0];
                c_d    = sum_ext[WIDTH];
                v_d    = arith_v;
            end
            FUNC_OR:  result = a | b;
            FUNC_AND: result = a & b;
            default:  result = '0;
        endcase
        z_d = (result == '0);
        n_d = result[WIDTH-1];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            z_q <= 1'b0;
            n_q <= 1'b0;
            c_q <= 1'b0;
            v_q <= 1'b0;
        end else begin
            z_q <= z_d;
            n_q <= n_d;
            c_q <= c_d;
            v_q <= v_d;
        end
    end

    assign flag_z = z_q;
    assign flag_n = n_q;
    assign flag_c = c_q;
    assign flag_v = v_q;

endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for alu.
// Each vector carries a hand-computed result and flag set, given as {z,n,c,v}.
module tb_alu;

    localparam int WIDTH = 32;

    logic             clock;
    logic             reset_n;
    logic [1:0]       func;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] result;
    logic             flag_z, flag_n, flag_c, flag_v;

    int n_checks;
    int n_pass;

    alu #(.WIDTH(WIDTH)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .func    (func),
        .a       (a),
        .b       (b),
        .result  (result),
        .flag_z  (flag_z),
        .flag_n  (flag_n),
        .flag_c  (flag_c),
        .flag_v  (flag_v)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
            $display("ok   %s got=%08h", tag, got);
        end else begin
            $display("FAIL %s got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] flags_now();
        return {28'd0, flag_z, flag_n, flag_c, flag_v};
    endfunction

    // Drive at negedge, check the combinational result, then check the captured flags after the edge.
    task automatic apply(input string tag, input logic [1:0] f, input logic [31:0] va,
                         input logic [31:0] vb, input logic [31:0] exp_res, input logic [3:0] exp_flags);
        @(negedge clock);
        func = f;
        a    = va;
        b    = vb;
        #1;
        check({tag, " result"}, result, exp_res);
        @(posedge clock);
        #1;
        check({tag, " flags"}, flags_now(), {28'd0, exp_flags});
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        reset_n  = 1'b0;
        func     = 2'd0;
        a        = '0;
        b        = '0;
        #3;
        check("reset flags", flags_now(), 32'd0);
        check("reset result", result, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        //       tag       func  a             b             result        zncv
        apply("add 2+3",   2'd0, 32'd2,        32'd3,        32'd5,        4'b0000);
        apply("add 5+3",   2'd0, 32'd5,        32'd3,        32'd8,        4'b0000);
        apply("sub 3-5",   2'd1, 32'd3,        32'd5,        32'hFFFFFFFE, 4'b0100);
        apply("sub 5-5",   2'd1, 32'd5,        32'd5,        32'd0,        4'b1010);
        apply("add wrap",  2'd0, 32'hFFFFFFFF, 32'd1,        32'd0,        4'b1010);
        apply("sub 0-0",   2'd1, 32'd0,        32'd0,        32'd0,        4'b1010);
        apply("sub ovf",   2'd1, 32'h80000000, 32'd1,        32'h7FFFFFFF, 4'b0011);
        apply("or",        2'd2, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0, 4'b0100);
        apply("and",       2'd3, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 4'b0000);
        apply("add ovf",   2'd0, 32'h7FFFFFFF, 32'd1,        32'h80000000, 4'b0101);

        // Asynchronous reset mid-cycle: the flags clear at once and the result is unaffected.
        #2;
        reset_n = 1'b0;
        #1;
        check("async rst flags", flags_now(), 32'd0);
        check("async rst result", result, 32'h80000000);
        @(posedge clock);
        #1;
        check("held rst flags", flags_now(), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        check("release pre-edge flags", flags_now(), 32'd0);
        @(posedge clock);
        #1;
        check("recapture flags", flags_now(), 32'h5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
